// File: rtl/maze_pkg.sv
// Shared types and sizes for the maze navigation controller.
// Map is MAZE_DIM x MAZE_DIM cells; row byte bit (7-c) is column c, 1 = open.
package maze_pkg;
   localparam int MAZE_DIM = 8;
   localparam int ROW_W    = 3;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY,
      ST_DONE,
      ST_FAIL
   } state_e;
endpackage

// File: rtl/maze_nav_ctrl_if.sv
// ROM read port plus move request/result handshake of the maze controller.
interface maze_nav_ctrl_if;
   import maze_pkg::*;

   logic                rom_en;
   logic [ROW_W-1:0]    rom_addr;
   logic [MAZE_DIM-1:0] rom_data;
   logic                move_valid;
   logic [1:0]          move_dir;
   logic                move_ready;
   logic                move_done;
   logic                move_ok;

   modport master (
      output rom_en, rom_addr, move_ready, move_done, move_ok,
      input  rom_data, move_valid, move_dir
   );

   modport slave (
      input  rom_en, rom_addr, move_ready, move_done, move_ok,
      output rom_data, move_valid, move_dir
   );
endinterface

// File: rtl/maze_bitmap.sv
// 8x8 map register file: row write port, combinational cell lookup,
// and a registered row read for the display.
module maze_bitmap
   import maze_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [ROW_W-1:0]    waddr,
   input  logic [MAZE_DIM-1:0] wdata,
   input  logic [ROW_W-1:0]    lk_row,
   input  logic [ROW_W-1:0]    lk_col,
   output logic                lk_bit,
   input  logic [ROW_W-1:0]    q_row,
   output logic [MAZE_DIM-1:0] q_bits
);
   logic [MAZE_DIM-1:0][MAZE_DIM-1:0] rows;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows   <= '0;
         q_bits <= '0;
      end else begin
         if (we) rows[waddr] <= wdata;
         q_bits <= rows[q_row];
      end
   end

   // column c is stored MSB-first, so it sits at bit (7-c)
   assign lk_bit = rows[lk_row][ROW_W'(MAZE_DIM-1) - lk_col];
endmodule

// File: rtl/maze_nav_ctrl.sv
// Maze sequencer: loads the map ROM into a bitmap on start, then judges
// player moves against it and flags arrival at the goal cell.
module maze_nav_ctrl
   import maze_pkg::*;
#(
   parameter int START_ROW = 0,
   parameter int START_COL = 7,
   parameter int GOAL_ROW  = 7,
   parameter int GOAL_COL  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   maze_nav_ctrl_if.master     bus,
   output logic [ROW_W-1:0]    pos_row,
   output logic [ROW_W-1:0]    pos_col,
   input  logic [ROW_W-1:0]    q_row,
   output logic [MAZE_DIM-1:0] q_bits,
   output logic                map_loaded,
   output logic                goal,
   output logic                start_blocked
);
   localparam logic [ROW_W-1:0] SR = ROW_W'(START_ROW);
   localparam logic [ROW_W-1:0] SC = ROW_W'(START_COL);
   localparam logic [ROW_W-1:0] GR = ROW_W'(GOAL_ROW);
   localparam logic [ROW_W-1:0] GC = ROW_W'(GOAL_COL);
   localparam logic [ROW_W-1:0] LAST = ROW_W'(MAZE_DIM-1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [ROW_W-1:0] tgt_row, tgt_col, lk_row, lk_col;
   logic             in_grid, lk_bit, tgt_ok, start_open, accept, start_go;

   assign start_go = start && (state != ST_LOAD);
   assign accept   = (state == ST_READY) && bus.move_valid && !start;
   assign tgt_ok   = in_grid && lk_bit;

   always_comb begin
      tgt_row = pos_row;
      tgt_col = pos_col;
      in_grid = 1'b1;
      case (dir_e'(bus.move_dir))
         DIR_UP:    begin in_grid = (pos_row != '0);   tgt_row = pos_row - 1'b1; end
         DIR_RIGHT: begin in_grid = (pos_col != LAST); tgt_col = pos_col + 1'b1; end
         DIR_DOWN:  begin in_grid = (pos_row != LAST); tgt_row = pos_row + 1'b1; end
         DIR_LEFT:  begin in_grid = (pos_col != '0);   tgt_col = pos_col - 1'b1; end
         default: ;
      endcase
   end

   // the lookup port checks the start cell while loading, the move target otherwise
   assign lk_row = (state == ST_LOAD) ? SR : tgt_row;
   assign lk_col = (state == ST_LOAD) ? SC : tgt_col;
   // the last row is written on the same edge that decides, so read it from the ROM bus
   assign start_open = (SR == LAST) ? bus.rom_data[LAST - SC] : lk_bit;

   maze_bitmap u_bitmap (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     ((state == ST_LOAD) && (cnt != '0)),
      .waddr  (ROW_W'(cnt - 1'b1)),
      .wdata  (bus.rom_data),
      .lk_row (lk_row),
      .lk_col (lk_col),
      .lk_bit (lk_bit),
      .q_row  (q_row),
      .q_bits (q_bits)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bus.rom_en    = 1'b0;
      bus.rom_addr  = '0;
      bus.move_ready = (state == ST_READY);
      map_loaded    = (state == ST_READY) || (state == ST_DONE);
      goal          = (state == ST_DONE);
      start_blocked = (state == ST_FAIL);
      if (state == ST_LOAD && cnt < CNT_W'(MAZE_DIM)) begin
         bus.rom_en   = 1'b1;
         bus.rom_addr = ROW_W'(cnt);
      end
      if (start_go) begin
         state_nxt = ST_LOAD;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_LOAD:
               if (cnt == CNT_W'(MAZE_DIM)) begin
                  if (!start_open)             state_nxt = ST_FAIL;
                  else if (SR == GR && SC == GC) state_nxt = ST_DONE;
                  else                         state_nxt = ST_READY;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            ST_READY:
               if (accept && tgt_ok && tgt_row == GR && tgt_col == GC) state_nxt = ST_DONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_row       <= SR;
         pos_col       <= SC;
         bus.move_done <= 1'b0;
         bus.move_ok   <= 1'b0;
      end else begin
         bus.move_done <= accept;
         if (accept) bus.move_ok <= tgt_ok;
         if (accept && tgt_ok) begin
            pos_row <= tgt_row;
            pos_col <= tgt_col;
         end else if (state == ST_LOAD && cnt == CNT_W'(MAZE_DIM) && !start_go) begin
            pos_row <= SR;
            pos_col <= SC;
         end
      end
   end
endmodule

// File: tb/tb_maze_nav_ctrl.sv
// Drives three parameter variants of maze_nav_ctrl in lockstep against a
// cell-level reference model of the load/move/goal rules.
module tb_maze_nav_ctrl;
   localparam int NDUT = 3;
   localparam int S_IDLE = 0, S_LOAD = 1, S_RDY = 2, S_DONE = 3, S_FAIL = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       move_valid = 1'b0;
   logic [1:0] move_dir = 2'd0;
   logic [2:0] q_row = 3'd0;
   logic [7:0] m [8];

   logic       o_en [NDUT];
   logic [2:0] o_addr [NDUT];
   logic       o_rdy [NDUT], o_done [NDUT], o_ok [NDUT];
   logic [2:0] o_pr [NDUT], o_pc [NDUT];
   logic [7:0] o_q [NDUT];
   logic       o_ml [NDUT], o_goal [NDUT], o_sb [NDUT];

   always #5 clk = ~clk;

   // variant 0: defaults; 1: goal one step below start; 2: start on a wall
   for (genvar g = 0; g < NDUT; g++) begin : gd
      maze_nav_ctrl_if bif ();
      assign bif.move_valid = move_valid;
      assign bif.move_dir   = move_dir;
      always @(posedge clk) if (bif.rom_en) bif.rom_data <= m[bif.rom_addr];

      maze_nav_ctrl #(
         .START_ROW (0),
         .START_COL ((g == 2) ? 0 : 7),
         .GOAL_ROW  ((g == 1) ? 1 : 7),
         .GOAL_COL  ((g == 1) ? 7 : 0)
      ) dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .start         (start),
         .bus           (bif),
         .pos_row       (o_pr[g]),
         .pos_col       (o_pc[g]),
         .q_row         (q_row),
         .q_bits        (o_q[g]),
         .map_loaded    (o_ml[g]),
         .goal          (o_goal[g]),
         .start_blocked (o_sb[g])
      );
      assign o_en[g]   = bif.rom_en;
      assign o_addr[g] = bif.rom_addr;
      assign o_rdy[g]  = bif.move_ready;
      assign o_done[g] = bif.move_done;
      assign o_ok[g]   = bif.move_ok;
   end

   function automatic int p_sc(int k); return (k == 2) ? 0 : 7; endfunction
   function automatic int p_gr(int k); return (k == 1) ? 1 : 7; endfunction
   function automatic int p_gc(int k); return (k == 1) ? 7 : 0; endfunction

   int         ms [NDUT], lc [NDUT], pr [NDUT], pc [NDUT];
   bit         mdone [NDUT], mok [NDUT];
   logic [7:0] mb [NDUT][8];
   int         n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input logic [2:0] qr, input bit qchk [NDUT]);
      for (int k = 0; k < NDUT; k++) begin
         bit en;
         en = (ms[k] == S_LOAD) && (lc[k] < 8);
         chk($sformatf("d%0d.rom_en", k), o_en[k], en);
         if (en) chk($sformatf("d%0d.rom_addr", k), o_addr[k], lc[k]);
         chk($sformatf("d%0d.move_ready", k), o_rdy[k], ms[k] == S_RDY);
         chk($sformatf("d%0d.move_done", k), o_done[k], mdone[k]);
         chk($sformatf("d%0d.move_ok", k), o_ok[k], mok[k]);
         chk($sformatf("d%0d.pos_row", k), o_pr[k], pr[k]);
         chk($sformatf("d%0d.pos_col", k), o_pc[k], pc[k]);
         chk($sformatf("d%0d.map_loaded", k), o_ml[k], ms[k] == S_RDY || ms[k] == S_DONE);
         chk($sformatf("d%0d.goal", k), o_goal[k], ms[k] == S_DONE);
         chk($sformatf("d%0d.start_blocked", k), o_sb[k], ms[k] == S_FAIL);
         if (qchk[k]) chk($sformatf("d%0d.q_bits[%0d]", k, qr), o_q[k], mb[k][qr]);
      end
   endtask

   // reference: one clock edge of the game rules for every variant
   task automatic model_edge(input bit st, input bit mv, input logic [1:0] dir);
      for (int k = 0; k < NDUT; k++) begin
         int nr, nc;
         bit ok;
         mdone[k] = 1'b0;
         if (st && ms[k] != S_LOAD) begin
            ms[k] = S_LOAD;
            lc[k] = 0;
         end else if (ms[k] == S_LOAD) begin
            if (lc[k] == 8) begin
               for (int r = 0; r < 8; r++) mb[k][r] = m[r];
               pr[k] = 0;
               pc[k] = p_sc(k);
               if (!mb[k][0][7 - pc[k]])                   ms[k] = S_FAIL;
               else if (pr[k] == p_gr(k) && pc[k] == p_gc(k)) ms[k] = S_DONE;
               else                                         ms[k] = S_RDY;
            end else begin
               lc[k]++;
            end
         end else if (ms[k] == S_RDY && mv) begin
            nr = pr[k] + ((dir == 2'd0) ? -1 : (dir == 2'd2) ? 1 : 0);
            nc = pc[k] + ((dir == 2'd1) ? 1 : (dir == 2'd3) ? -1 : 0);
            ok = (nr >= 0 && nr < 8 && nc >= 0 && nc < 8);
            if (ok) ok = mb[k][nr][7 - nc];
            mdone[k] = 1'b1;
            mok[k]   = ok;
            if (ok) begin
               pr[k] = nr;
               pc[k] = nc;
               if (nr == p_gr(k) && nc == p_gc(k)) ms[k] = S_DONE;
            end
         end
      end
   endtask

   task automatic step(input bit st, input bit mv, input logic [1:0] dir, input logic [2:0] qr);
      bit qchk [NDUT];
      start = st; move_valid = mv; move_dir = dir; q_row = qr;
      @(posedge clk);
      for (int k = 0; k < NDUT; k++) qchk[k] = (ms[k] != S_LOAD);
      model_edge(st, mv, dir);
      #1;
      start = 1'b0; move_valid = 1'b0;
      check_all(qr, qchk);
   endtask

   task automatic do_reset();
      bit qchk [NDUT];
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         ms[k] = S_IDLE; lc[k] = 0; pr[k] = 0; pc[k] = p_sc(k);
         mdone[k] = 1'b0; mok[k] = 1'b0; qchk[k] = 1'b1;
         for (int r = 0; r < 8; r++) mb[k][r] = 8'h00;
      end
      check_all(q_row, qchk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] qr);
      step(1'b1, 1'b0, 2'd0, qr);
      repeat (9) step(1'b0, 1'b0, 2'd0, qr);
   endtask

   initial begin
      logic [7:0] spec_map [8];
      spec_map = '{8'h3F, 8'h61, 8'h4D, 8'hE5, 8'hB7, 8'h11, 8'hF7, 8'h8C};
      for (int r = 0; r < 8; r++) m[r] = spec_map[r];
      #2;
      do_reset();

      // reference map: load, query row 4, down then left
      load(3'd4);
      step(1'b0, 1'b0, 2'd0, 3'd4);
      step(1'b0, 1'b1, 2'd2, 3'd4);
      step(1'b0, 1'b1, 2'd3, 3'd4);
      step(1'b0, 1'b1, 2'd2, 3'd4);

      // reload, then right off the edge and left into the open cell
      load(3'd0);
      step(1'b0, 1'b1, 2'd1, 3'd1);
      step(1'b0, 1'b1, 2'd3, 3'd2);

      // start and move together: the move is dropped
      step(1'b1, 1'b1, 2'd3, 3'd0);
      repeat (9) step(1'b0, 1'b0, 2'd0, 3'd0);

      // reset in the middle of a load, then a full reload with row readback
      step(1'b1, 1'b0, 2'd0, 3'd0);
      repeat (4) step(1'b0, 1'b0, 2'd0, 3'd0);
      do_reset();
      load(3'd7);
      for (int r = 0; r < 8; r++) step(1'b0, 1'b0, 2'd0, 3'(r));

      // random maps and random move streams, back-to-back moves included
      for (int it = 0; it < 12; it++) begin
         repeat (10) step(1'b0, 1'b0, 2'd0, 3'($urandom));
         for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
         if ($urandom_range(0, 6) != 0) m[0][0] = 1'b1;
         if ($urandom_range(0, 2) != 0) m[0][7] = 1'b1;
         load(3'($urandom));
         for (int s = 0; s < 40; s++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom), 3'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/maze_nav_ctrl.md
Name: maze_nav_ctrl

Overview:
- Sequencer and owner of one maze map ROM (8 rows x 8 bits, registered read, 1-cycle latency).
- On a start pulse it walks the ROM, reads all 8 row bytes into an internal 8x8 bitmap, and places the player at a start cell.
- It then accepts move requests, checks the target cell against the bitmap, updates the player position and flags arrival at the goal.
- Sits between the map ROM and the game/display logic; it is the only master of the ROM's en/addr pins.

Parameters:
- START_ROW, 0, row of the initial player cell (0..7).
- START_COL, 7, column of the initial player cell (0..7).
- GOAL_ROW, 7, row of the goal cell.
- GOAL_COL, 0, column of the goal cell.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; (re)load the map and reset the player. Ignored while in LOAD.
- rom_en  out  1  ROM read enable.
- rom_addr  out  3  ROM row address.
- rom_data  in  8  ROM row data, valid the cycle after rom_en/rom_addr.
- move_valid  in  1  move request.
- move_dir  in  2  00 up (row-1), 01 right (col+1), 10 down (row+1), 11 left (col-1).
- move_ready  out  1  high only in READY.
- move_done  out  1  1-cycle pulse, the cycle after an accepted move.
- move_ok  out  1  result of the last move, valid with move_done and held until the next one.
- pos_row  out  3  current player row.
- pos_col  out  3  current player column.
- q_row  in  3  display query row.
- q_bits  out  8  registered bitmap row q_row, 1-cycle latency.
- map_loaded  out  1  high in READY and DONE.
- goal  out  1  high in DONE.
- start_blocked  out  1  high in FAIL.

Behaviour:
- Bit mapping: row byte bit (7-c) is column c. Bit value 1 = open, 0 = wall.
- Reset (rst_n low, asynchronous):
  - state IDLE; bitmap all 0; counter 0.
  - rom_en=0, rom_addr=0, move_ready=0, move_done=0, move_ok=0.
  - pos_row=START_ROW, pos_col=START_COL.
  - q_bits=0, map_loaded=0, goal=0, start_blocked=0.
- States: IDLE, LOAD, READY, DONE, FAIL. A start pulse in IDLE/READY/DONE/FAIL enters LOAD with cnt=0 and clears goal, map_loaded and start_blocked.
- LOAD (cnt 0..8, 9 cycles):
  - While cnt<8: rom_en=1, rom_addr=cnt.
  - While cnt>=1: row[cnt-1] <= rom_data.
  - At cnt=8: rom_en=0. Next state is FAIL if the start cell is 0 (taken from the loaded data, including the row captured this cycle); otherwise READY with pos = START.
  - If the start cell equals the goal cell and is open, next state is DONE.
- READY:
  - move_ready=1; a move is accepted when move_valid=1.
  - Target = pos + dir. Target is rejected if it is off the grid (no wrap-around: row 0 up, row 7 down, col 0 left, col 7 right) or its bitmap cell is 0.
  - Next cycle: move_done=1 and move_ok set. On success pos updates in that same cycle.
  - On success with target == goal: next state DONE.
  - Back-to-back moves are allowed every cycle, each judged against the already updated pos.
- DONE: goal=1, move_ready=0, moves ignored.
- FAIL: start_blocked=1, move_ready=0, moves ignored.
- start and move_valid in the same cycle while in READY: start wins, the move is dropped, no move_done.
- The q_bits query works in every state. During LOAD it returns the partially loaded bitmap.
- Reset asserted mid-LOAD aborts immediately; the ROM is left idle.

Decomposition:
- Shared package maze_pkg holds:
  - direction encodings DIR_UP/RIGHT/DOWN/LEFT;
  - state encodings;
  - MAZE_DIM=8 and ROW_W=3.
- One sub-module, maze_bitmap: 8x8 register file with row write port, combinational cell lookup (row,col) and a registered row read for q_bits.
- The FSM, load counter and position/move logic live in maze_nav_ctrl.

Test Plan:
- Map rows 3F,61,4D,E5,B7,11,F7,8C, defaults, start pulse -> rom_addr 0..7 over 8 cycles, map_loaded rises 9 cycles after LOAD entry, pos=(0,7), q_row=4 gives q_bits=B7 one cycle later.
- Same map, moves down then left -> first: ok=1, pos=(1,7); second: target (1,6) bit is 0, ok=0, pos stays (1,7).
- From (0,7): right -> ok=0 (off grid, no wrap); left -> ok=1, pos=(0,6).
- GOAL_ROW=1, GOAL_COL=7, move down -> move_done with ok=1, goal=1, move_ready=0; a further move_valid produces no move_done.
- START_COL=0 (cell closed in row 3F) -> after load, start_blocked=1 and map_loaded=0; a new start pulse re-enters LOAD.
- rst_n low at LOAD cnt=4 -> all outputs at reset values immediately; a start pulse after release reloads a complete, correct bitmap.
